register_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the rv32 core: N read ports, M write ports, optional write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode/issue (read, issue-mark) and writeback (write, busy-clear).
- Replaces the fixed 2-read/1-write file so wider or dual-issue pipelines can use one block.
- x0 is hardwired to zero.

---
 rtl/register_file_mp.sv | 124 ++++++++++++
 tb/tb_register_file_mp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port integer register file: N combinational read ports, M write ports,
// optional write-to-read forwarding and a per-register busy scoreboard. x0 reads as zero.

module register_file_mp_rport #(
  parameter int NRegs       = 32,
  parameter int XLen        = 32,
  parameter int NWritePorts = 1,
  parameter int Bypass      = 1,
  parameter int AddrW       = $clog2(NRegs)
) (
  input  logic                                nRst,
  input  logic [AddrW-1:0]                    addr,
  input  logic [NRegs-1:0][XLen-1:0]          rf,
  input  logic [NRegs-1:0]                    busy,
  input  logic [NWritePorts-1:0]              we,
  input  logic [NWritePorts-1:0][AddrW-1:0]   wa,
  input  logic [NWritePorts-1:0][XLen-1:0]    wd,
  input  logic                                issue_en,
  input  logic [AddrW-1:0]                    issue_rd,
  output logic [XLen-1:0]                     rs,
  output logic                                rs_busy
);
  logic            hit;
  logic [XLen-1:0] fwd;

  always_comb begin
    hit = 1'b0;
    fwd = '0;
    // Ascending scan: the highest-indexed matching port is the one forwarded.
    for (int w = 0; w < NWritePorts; w++)
      if (we[w] && wa[w] == addr) begin
        hit = 1'b1;
        fwd = wd[w];
      end
    rs      = rf[addr];
    rs_busy = busy[addr];
    if (Bypass != 0 && hit && addr != '0) begin
      rs = fwd;
      // A same-cycle issue to this register means a newer producer is in flight.
      if (!(issue_en && issue_rd == addr)) rs_busy = 1'b0;
    end
    if (!nRst) begin
      rs      = '0;
      rs_busy = 1'b0;
    end
  end
endmodule

module register_file_mp #(
  parameter int NRegs       = 32,
  parameter int XLen        = 32,
  parameter int NReadPorts  = 2,
  parameter int NWritePorts = 1,
  parameter int Bypass      = 1,
  parameter int AddrW       = $clog2(NRegs)
) (
  input  logic                                iClk,
  input  logic                                nRst,
  input  logic [NWritePorts-1:0]              iWriteEn,
  input  logic [NWritePorts-1:0][AddrW-1:0]   iAddr_Rd,
  input  logic [NWritePorts-1:0][XLen-1:0]    iRd,
  input  logic [NReadPorts-1:0][AddrW-1:0]    iAddr_Rs,
  output logic [NReadPorts-1:0][XLen-1:0]     oRs,
  output logic [NReadPorts-1:0]               oRsBusy,
  input  logic                                iIssueEn,
  input  logic [AddrW-1:0]                    iIssueRd,
  input  logic                                iFlush
);
  logic [NRegs-1:0][XLen-1:0] rf;
  logic [NRegs-1:0]           busy;

  assign rf[0]   = '0;
  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NRegs; g++) begin : g_reg
    logic            we, set, b_q;
    logic [XLen-1:0] wd, q;

    always_comb begin
      we = 1'b0;
      wd = q;
      for (int w = 0; w < NWritePorts; w++)
        if (iWriteEn[w] && iAddr_Rd[w] == AddrW'(g)) begin
          we = 1'b1;
          wd = iRd[w];
        end
    end

    assign set = iIssueEn && iIssueRd == AddrW'(g);

    always_ff @(posedge iClk or negedge nRst)
      if (!nRst)   q <= '0;
      else if (we) q <= wd;

    // Flush beats everything; issue beats a same-cycle writeback.
    always_ff @(posedge iClk or negedge nRst)
      if (!nRst)       b_q <= 1'b0;
      else if (iFlush) b_q <= 1'b0;
      else if (set)    b_q <= 1'b1;
      else if (we)     b_q <= 1'b0;

    assign rf[g]   = q;
    assign busy[g] = b_q;
  end

  for (genvar r = 0; r < NReadPorts; r++) begin : g_rport
    register_file_mp_rport #(
      .NRegs(NRegs), .XLen(XLen), .NWritePorts(NWritePorts),
      .Bypass(Bypass), .AddrW(AddrW)
    ) u_rport (
      .nRst    (nRst),
      .addr    (iAddr_Rs[r]),
      .rf      (rf),
      .busy    (busy),
      .we      (iWriteEn),
      .wa      (iAddr_Rd),
      .wd      (iRd),
      .issue_en(iIssueEn),
      .issue_rd(iIssueRd),
      .rs      (oRs[r]),
      .rs_busy (oRsBusy[r])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a forwarding and a non-forwarding instance share stimulus
// and are compared every cycle against an array/scoreboard model of the register file.

module tb_register_file_mp;
  localparam int NR = 32, XL = 32, NRP = 2, NWP = 2, AW = 5;

  logic                    iClk = 1'b0;
  logic                    nRst;
  logic [NWP-1:0]          iWriteEn;
  logic [NWP-1:0][AW-1:0]  iAddr_Rd;
  logic [NWP-1:0][XL-1:0]  iRd;
  logic [NRP-1:0][AW-1:0]  iAddr_Rs;
  logic [NRP-1:0][XL-1:0]  rs_b, rs_nb;
  logic [NRP-1:0]          busy_b, busy_nb;
  logic                    iIssueEn;
  logic [AW-1:0]           iIssueRd;
  logic                    iFlush;

  always #5 iClk = ~iClk;

  register_file_mp #(.NRegs(NR), .XLen(XL), .NReadPorts(NRP), .NWritePorts(NWP), .Bypass(1)) u_dut (
    .iClk(iClk), .nRst(nRst), .iWriteEn(iWriteEn), .iAddr_Rd(iAddr_Rd), .iRd(iRd),
    .iAddr_Rs(iAddr_Rs), .oRs(rs_b), .oRsBusy(busy_b),
    .iIssueEn(iIssueEn), .iIssueRd(iIssueRd), .iFlush(iFlush));

  register_file_mp #(.NRegs(NR), .XLen(XL), .NReadPorts(NRP), .NWritePorts(NWP), .Bypass(0)) u_dut_nb (
    .iClk(iClk), .nRst(nRst), .iWriteEn(iWriteEn), .iAddr_Rd(iAddr_Rd), .iRd(iRd),
    .iAddr_Rs(iAddr_Rs), .oRs(rs_nb), .oRsBusy(busy_nb),
    .iIssueEn(iIssueEn), .iIssueRd(iIssueRd), .iFlush(iFlush));

  logic [31:0] mem [NR];
  bit          bsy [NR];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Index of the write port whose data lands in register a this cycle, -1 if none.
  function automatic int winner(int a);
    int res = -1;
    if (a == 0) return -1;
    for (int w = 0; w < NWP; w++)
      if (iWriteEn[w] && int'(iAddr_Rd[w]) == a) res = w;
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 1; i < NR; i++) begin
      int wn = winner(i);
      if (wn >= 0) mem[i] = iRd[wn];
    end
    if (iFlush) begin
      for (int i = 0; i < NR; i++) bsy[i] = 1'b0;
    end else begin
      for (int w = 0; w < NWP; w++) if (iWriteEn[w]) bsy[iAddr_Rd[w]] = 1'b0;
      if (iIssueEn && iIssueRd != 0) bsy[iIssueRd] = 1'b1;
    end
  endtask

  task automatic check_outs();
    int a, wn;
    logic [31:0] st, eb;
    logic bs, bb;
    for (int r = 0; r < NRP; r++) begin
      a  = int'(iAddr_Rs[r]);
      wn = winner(a);
      st = (a == 0) ? 32'h0 : mem[a];
      bs = (a == 0) ? 1'b0 : bsy[a];
      eb = (wn >= 0) ? iRd[wn] : st;
      bb = bs;
      if (wn >= 0 && !(iIssueEn && int'(iIssueRd) == a)) bb = 1'b0;
      if (!nRst) begin st = '0; eb = '0; bs = 1'b0; bb = 1'b0; end
      chk($sformatf("rs_byp[%0d] x%0d", r, a), rs_b[r], eb);
      chk($sformatf("busy_byp[%0d] x%0d", r, a), {31'h0, busy_b[r]}, {31'h0, bb});
      chk($sformatf("rs_nobyp[%0d] x%0d", r, a), rs_nb[r], st);
      chk($sformatf("busy_nobyp[%0d] x%0d", r, a), {31'h0, busy_nb[r]}, {31'h0, bs});
    end
  endtask

  task automatic cycle();
    #1 check_outs();
    @(posedge iClk);
    if (nRst) model_edge();
    @(negedge iClk);
  endtask

  task automatic idle();
    iWriteEn = '0; iAddr_Rd = '0; iRd = '0;
    iIssueEn = 1'b0; iIssueRd = '0; iFlush = 1'b0;
  endtask

  task automatic rd(int a0, int a1);
    iAddr_Rs[0] = AW'(a0);
    iAddr_Rs[1] = AW'(a1);
  endtask

  task automatic wr(int w, int a, logic [31:0] d);
    iWriteEn[w] = 1'b1;
    iAddr_Rd[w] = AW'(a);
    iRd[w]      = d;
  endtask

  task automatic issue(int a);
    iIssueEn = 1'b1;
    iIssueRd = AW'(a);
  endtask

  initial begin
    idle();
    rd(0, 0);
    nRst = 1'b0;
    model_reset();
    @(negedge iClk);

    // Outputs held at zero in reset, even with writes and issues driven.
    for (int a = 0; a < NR; a++) begin
      idle(); wr(0, a, 32'hFFFF_0000 | a); wr(1, a, 32'h1234_0000 | a); issue(a);
      rd(a, NR - 1 - a);
      cycle();
    end
    nRst = 1'b1;

    idle(); wr(0, 5, 32'hDEADBEEF); rd(5, 5); cycle();
    idle(); rd(5, 5); cycle();

    idle(); wr(0, 0, 32'hFFFFFFFF); rd(0, 0); cycle();
    idle(); rd(0, 0); cycle();
    idle(); issue(0); rd(0, 0); cycle();
    idle(); rd(0, 0); cycle();

    idle(); wr(0, 7, 32'h12345678); rd(7, 7); cycle();
    idle(); rd(7, 7); cycle();

    idle(); wr(0, 3, 32'h1); wr(1, 3, 32'h2); rd(3, 3); cycle();
    idle(); rd(3, 3); cycle();

    idle(); issue(9); rd(9, 9); cycle();
    idle(); rd(9, 9); cycle();
    idle(); wr(0, 9, 32'h99); issue(9); rd(9, 9); cycle();
    idle(); rd(9, 9); cycle();
    idle(); wr(1, 9, 32'h999); rd(9, 9); cycle();
    idle(); rd(9, 9); cycle();

    idle(); issue(4); cycle();
    idle(); issue(6); rd(4, 6); cycle();
    idle(); issue(8); iFlush = 1'b1; rd(4, 6); cycle();
    idle(); rd(4, 6); cycle();
    idle(); rd(8, 0); cycle();

    // Asynchronous reset mid-cycle, away from any clock edge.
    idle(); wr(0, 10, 32'hA5); cycle();
    idle(); issue(10); rd(10, 10); #1 check_outs();
    #1 nRst = 1'b0;
    model_reset();
    #1 check_outs();
    @(negedge iClk);
    nRst = 1'b1;
    idle(); rd(10, 10); cycle();

    for (int i = 0; i < 400; i++) begin
      idle();
      for (int w = 0; w < NWP; w++)
        if ($urandom_range(0, 1) == 1) wr(w, $urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 1) == 1) issue($urandom_range(0, 15));
      iFlush = ($urandom_range(0, 19) == 0);
      rd($urandom_range(0, 15), $urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
